seq_multiplier: RTL
===================

Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier.
- Successor to the 4-bit combinational unsigned multiplier in the ALU datapath.
- Generalises operand width, adds a signed/unsigned mode, and uses a start/busy/done handshake.
- Processes one multiplier bit per clock, so a wide multiply costs area proportional to WIDTH rather than WIDTH².

Parameters:
WIDTH, 8, operand width in bits (>= 2); product width is 2*WIDTH.

Ports:
i_clk  input  1  system clock, rising-edge active
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  request; sampled only in IDLE
i_signed  input  1  1 = two's-complement operands and result, 0 = unsigned; sampled with i_start
i_op1  input  WIDTH  multiplicand; sampled with i_start
i_op2  input  WIDTH  multiplier; sampled with i_start
o_busy  output  1  high while an operation is in progress (CALC or DONE)
o_done  output  1  one-cycle pulse when o_mult is updated
o_mult  output  2*WIDTH  product; holds last result until the next o_done

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low: i_clk, i_rst_n.
  - While i_rst_n=0: state=IDLE; o_busy=0, o_done=0, o_mult=0; all internal registers cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - If i_start=1 at a rising edge, capture operands and go to CALC.
  - Else remain in IDLE.
- Operand capture:
  - Unsigned mode: magnitudes are i_op1 and i_op2, zero-extended to 2*WIDTH / WIDTH.
  - Signed mode: each magnitude is the two's-complement absolute value. The most-negative value maps to 2^(WIDTH-1), which fits unsigned in WIDTH bits.
  - neg flag = i_signed & (i_op1[MSB] ^ i_op2[MSB]).
  - Accumulator cleared; step counter cleared.
- CALC, each cycle:
  - If multiplier LSB=1, accumulator += multiplicand, mod 2^(2*WIDTH).
  - Multiplicand shifts left 1; multiplier shifts right 1; counter increments.
  - After WIDTH steps, go to DONE.
- DONE, one cycle:
  - o_mult <= neg ? two's-complement negation of accumulator : accumulator.
  - o_done=1 for this cycle only.
  - Next state is IDLE.
- Latency: o_done is high exactly WIDTH+1 rising edges after the edge that sampled i_start.
- Back-to-back: the earliest next start is sampled one cycle after o_done, which is the first IDLE cycle.
- o_busy is high in CALC and DONE, low in IDLE. It is registered and rises one edge after i_start is sampled.
- i_start while busy is ignored, with no queuing. Operand and mode changes during CALC/DONE have no effect.
- Results are exact for all operand pairs:
  - unsigned max (2^W-1)² fits in 2W bits;
  - signed (-2^(W-1))² = 2^(2W-2) fits positive in 2W bits.
- Zero operands give o_mult=0 with neg suppressed. Negating 0 yields 0, so no special case is needed.
- Reset asserted mid-operation aborts immediately to IDLE. o_mult is cleared and no o_done is issued.
- o_mult changes only on a DONE cycle or on reset.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- When defined, CALC exits to DONE after the step that leaves the shifted multiplier register equal to zero. At least one CALC step is always taken.
- Latency becomes n+1 edges from the start sample, where n = max(1, index of the highest set bit of |op2| + 1).
  - Example: W=8, op2=3 gives n=2 and o_done 3 edges after start.
  - op2=0 gives n=1, o_done after 2 edges.
- Product values are identical with and without the macro.
- When undefined, latency is fixed at WIDTH+1 regardless of data.

Test Plan:
- Exhaustive sweep: WIDTH=4, unsigned, all 256 op pairs, with a golden model of op1*op2. Required: zero mismatches, and o_done exactly 5 edges after each start (macro off).
- Signed corners: WIDTH=8, signed. Required products:
  - (-128)*(-128) -> 16384;
  - (-128)*127 -> -16256 (0xC080);
  - (-1)*1 -> 0xFFFF;
  - 0*(-5) -> 0.
- Unsigned max: WIDTH=8, 255*255 -> 65025 (0xFE01), with neg ignored.
- Start during busy: a second i_start with different operands pulsed mid-CALC. Required: first result unchanged, exactly one o_done, and the second request not executed.
- Reset mid-operation: i_rst_n low for 1 cycle at CALC step 3. Required: o_busy=0, o_mult=0, no o_done; a following 6*7 unsigned start yields 42.
- Early termination (SEQ_MULT_EARLY_TERM_EN defined), WIDTH=8: 200*3 -> 600 with o_done 3 edges after start; 9*0 -> 0 with o_done 2 edges after start.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock.
// Unsigned or two's-complement operands, start/busy/done handshake.
// Optional macro SEQ_MULT_EARLY_TERM_EN: leave CALC as soon as the shifted multiplier
// register becomes zero (at least one step is always taken).
module seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_signed,
  input  logic [WIDTH-1:0]     i_op1,
  input  logic [WIDTH-1:0]     i_op2,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_mult
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] OneW = WIDTH'(1);
  localparam logic [PW-1:0]    OneP = PW'(1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PW-1:0]     mult_q, mult_d;

  logic [WIDTH-1:0]  mag1, mag2;
  logic [WIDTH-1:0]  mplier_shift;
  logic              last_step;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), still fits unsigned.
  always_comb begin
    mag1 = (i_signed && i_op1[WIDTH-1]) ? (~i_op1 + OneW) : i_op1;
    mag2 = (i_signed && i_op2[WIDTH-1]) ? (~i_op2 + OneW) : i_op2;
  end

  // Decide whether the current CALC step is the final one.
  always_comb begin
    mplier_shift = mplier_q >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
    last_step = (mplier_shift == '0) || (cnt_q == CntW'(WIDTH - 1));
`else
    last_step = (cnt_q == CntW'(WIDTH - 1));
`endif
  end

  // Next-state logic for the FSM and datapath registers.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    mult_d   = mult_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_start) begin
          mcand_d  = {{WIDTH{1'b0}}, mag1};
          mplier_d = mag2;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = i_signed & (i_op1[WIDTH-1] ^ i_op2[WIDTH-1]);
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + 1'b1;
        if (last_step) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Negating a zero accumulator yields zero, so no zero-operand special case.
        mult_d  = neg_q ? (~acc_q + OneP) : acc_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and registered outputs; reset aborts any operation without a done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mult_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mult_q   <= mult_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_mult = mult_q;

endmodule
